// File: rtl/ext_share_arbiter.sv
// rtl/ext_share_arbiter.sv - two-requester arbiter sharing one 16-to-32 extend unit
module ext_share_arbiter #(
    parameter bit RR_EN   = 1'b1,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm16,
    input  logic [1:0]  req0_ExtOp,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm16,
    input  logic [1:0]  req1_ExtOp,
    output logic        req1_ready,
    output logic [15:0] ext_imm16,
    output logic [1:0]  ext_ExtOp,
    input  logic [31:0] ext_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] buf_imm16;
    logic [1:0]  buf_ext_op;
    logic        buf_id;
    logic        prio;
    logic        can_accept;
    logic        grant;
    logic        winner;

    // Arbitration and buffer next-state; readies are suppressed during reset
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        winner     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        can_accept = (state == EMPTY) || rsp_ready;
        if (!rst && can_accept && (req0_valid || req1_valid)) begin
            grant = 1'b1;
            if (req0_valid && req1_valid) begin
                winner = RR_EN ? prio : 1'b0;
            end else begin
                winner = req1_valid;
            end
            req0_ready = ~winner;
            req1_ready = winner;
        end
        case (state)
            EMPTY: begin
                if (grant) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !grant) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Buffer occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // One-entry payload buffer; held whenever there is no grant
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_imm16  <= 16'h0000;
            buf_ext_op <= 2'b00;
            buf_id     <= 1'b0;
        end else if (grant) begin
            buf_imm16  <= winner ? req1_imm16 : req0_imm16;
            buf_ext_op <= winner ? req1_ExtOp : req0_ExtOp;
            buf_id     <= winner;
        end
    end

    // Round-robin pointer: the loser of each grant gets priority next
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= RR_INIT;
        end else if (RR_EN && grant) begin
            prio <= ~winner;
        end
    end

    assign ext_imm16 = buf_imm16;
    assign ext_ExtOp = buf_ext_op;
    assign rsp_valid = (state == FULL);
    assign rsp_id    = buf_id;
    assign rsp_data  = ext_out;

endmodule

// File: tb/tb_ext_share_arbiter.sv
// tb/tb_ext_share_arbiter.sv - directed self-checking bench for ext_share_arbiter
module tb_ext_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_imm16;
    logic [1:0]  req0_ExtOp;
    logic        req1_valid;
    logic [15:0] req1_imm16;
    logic [1:0]  req1_ExtOp;
    logic        rsp_ready;

    logic        a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id;
    logic [15:0] a_ext_imm16;
    logic [1:0]  a_ext_ExtOp;
    logic [31:0] a_ext_out, a_rsp_data;

    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id;
    logic [15:0] f_ext_imm16;
    logic [1:0]  f_ext_ExtOp;
    logic [31:0] f_ext_out, f_rsp_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] op);
        case (op)
            2'b00:   extend = {16'h0000, imm};
            2'b01:   extend = {{16{imm[15]}}, imm};
            2'b10:   extend = {imm, 16'h0000};
            default: extend = {32{imm[15]}};
        endcase
    endfunction

    assign a_ext_out = extend(a_ext_imm16, a_ext_ExtOp);
    assign f_ext_out = extend(f_ext_imm16, f_ext_ExtOp);

    ext_share_arbiter #(.RR_EN(1'b1), .RR_INIT(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_imm16(req0_imm16), .req0_ExtOp(req0_ExtOp), .req0_ready(a_req0_ready),
        .req1_valid(req1_valid), .req1_imm16(req1_imm16), .req1_ExtOp(req1_ExtOp), .req1_ready(a_req1_ready),
        .ext_imm16(a_ext_imm16), .ext_ExtOp(a_ext_ExtOp), .ext_out(a_ext_out),
        .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .rsp_ready(rsp_ready)
    );

    ext_share_arbiter #(.RR_EN(1'b0), .RR_INIT(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_imm16(req0_imm16), .req0_ExtOp(req0_ExtOp), .req0_ready(f_req0_ready),
        .req1_valid(req1_valid), .req1_imm16(req1_imm16), .req1_ExtOp(req1_ExtOp), .req1_ready(f_req1_ready),
        .ext_imm16(f_ext_imm16), .ext_ExtOp(f_ext_ExtOp), .ext_out(f_ext_out),
        .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data), .rsp_ready(rsp_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req0_imm16 = 16'h0; req0_ExtOp = 2'b00;
        req1_valid = 1'b0; req1_imm16 = 16'h0; req1_ExtOp = 2'b00;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); else passed++;
        total++; if (a_rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %b want 0", a_rsp_id); else passed++;
        total++; if (a_ext_imm16 !== 16'h0000) $display("FAIL reset_ext_imm16 got %h want 0000", a_ext_imm16); else passed++;
        total++; if (a_ext_ExtOp !== 2'b00) $display("FAIL reset_ext_ExtOp got %b want 00", a_ext_ExtOp); else passed++;
        total++; if (a_rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", a_rsp_data); else passed++;
        total++; if (f_rsp_valid !== 1'b0) $display("FAIL reset_fp_rsp_valid got %b want 0", f_rsp_valid); else passed++;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_imm16 = 16'h8001; req0_ExtOp = 2'b01;
        rsp_ready = 1'b1;
        #2;
        total++; if (a_req0_ready !== 1'b1) $display("FAIL single_req0_ready got %b want 1", a_req0_ready); else passed++;
        total++; if (a_req1_ready !== 1'b0) $display("FAIL single_req1_ready got %b want 0", a_req1_ready); else passed++;
        tick();
        req0_valid = 1'b0;
        total++; if (a_rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b want 1", a_rsp_valid); else passed++;
        total++; if (a_rsp_id !== 1'b0) $display("FAIL single_rsp_id got %b want 0", a_rsp_id); else passed++;
        total++; if (a_rsp_data !== 32'hFFFF8001) $display("FAIL single_rsp_data got %h want ffff8001", a_rsp_data); else passed++;
        tick();
        total++; if (a_rsp_valid !== 1'b0) $display("FAIL drain_rsp_valid got %b want 0", a_rsp_valid); else passed++;
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [31:0] exp_data;
        do_reset();
        req0_valid = 1'b1; req0_imm16 = 16'h1234; req0_ExtOp = 2'b10;
        req1_valid = 1'b1; req1_imm16 = 16'h00F0; req1_ExtOp = 2'b00;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id   = k[0];
            exp_data = exp_id ? 32'h000000F0 : 32'h12340000;
            #2;
            total++; if (a_req0_ready !== ~exp_id || a_req1_ready !== exp_id)
                $display("FAIL rr_ready[%0d] got %b%b want %b%b", k, a_req1_ready, a_req0_ready, exp_id, ~exp_id); else passed++;
            total++; if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0)
                $display("FAIL fp_ready[%0d] got %b%b want 01", k, f_req1_ready, f_req0_ready); else passed++;
            tick();
            total++; if (a_rsp_id !== exp_id || a_rsp_data !== exp_data)
                $display("FAIL rr_rsp[%0d] got id %b data %h want id %b data %h", k, a_rsp_id, a_rsp_data, exp_id, exp_data); else passed++;
            total++; if (f_rsp_id !== 1'b0 || f_rsp_data !== 32'h12340000)
                $display("FAIL fp_rsp[%0d] got id %b data %h want id 0 data 12340000", k, f_rsp_id, f_rsp_data); else passed++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_imm16 = 16'h8001; req0_ExtOp = 2'b01;
        rsp_ready = 1'b1;
        #2;
        total++; if (a_req0_ready !== 1'b1) $display("FAIL bp_load_ready got %b want 1", a_req0_ready); else passed++;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_imm16 = 16'h7FFF; req1_ExtOp = 2'b11;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            total++; if (a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0)
                $display("FAIL bp_ready[%0d] got %b%b want 00", k, a_req1_ready, a_req0_ready); else passed++;
            tick();
            total++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'b0 || a_rsp_data !== 32'hFFFF8001 || a_ext_imm16 !== 16'h8001)
                $display("FAIL bp_hold[%0d] got v %b id %b data %h imm %h want v 1 id 0 data ffff8001 imm 8001",
                         k, a_rsp_valid, a_rsp_id, a_rsp_data, a_ext_imm16); else passed++;
        end
        rsp_ready = 1'b1;
        #2;
        total++; if (a_req1_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", a_req1_ready); else passed++;
        tick();
        total++; if (a_rsp_id !== 1'b1 || a_rsp_data !== 32'h00000000)
            $display("FAIL op11_pos got id %b data %h want id 1 data 00000000", a_rsp_id, a_rsp_data); else passed++;
        req1_imm16 = 16'h8000; req1_ExtOp = 2'b11;
        #2;
        total++; if (a_req1_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", a_req1_ready); else passed++;
        tick();
        total++; if (a_rsp_id !== 1'b1 || a_rsp_data !== 32'hFFFFFFFF)
            $display("FAIL op11_neg got id %b data %h want id 1 data ffffffff", a_rsp_id, a_rsp_data); else passed++;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1; req0_imm16 = 16'h1234; req0_ExtOp = 2'b10;
        req1_valid = 1'b1; req1_imm16 = 16'h00F0; req1_ExtOp = 2'b00;
        #2;
        total++; if (a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0)
            $display("FAIL rstmid_ready got %b%b want 00", a_req1_ready, a_req0_ready); else passed++;
        tick();
        rst = 1'b0;
        total++; if (a_rsp_valid !== 1'b0 || a_rsp_id !== 1'b0 || a_ext_imm16 !== 16'h0000)
            $display("FAIL rstmid_state got v %b id %b imm %h want v 0 id 0 imm 0000", a_rsp_valid, a_rsp_id, a_ext_imm16); else passed++;
        rsp_ready = 1'b1;
        #2;
        total++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0)
            $display("FAIL rstmid_prio got %b%b want 01", a_req1_ready, a_req0_ready); else passed++;
        tick();
        total++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'b0 || a_rsp_data !== 32'h12340000)
            $display("FAIL rstmid_rsp got v %b id %b data %h want v 1 id 0 data 12340000", a_rsp_valid, a_rsp_id, a_rsp_data); else passed++;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ext_share_arbiter.md
Name: ext_share_arbiter

Overview:
- Shares one combinational 16-to-32 extend unit between two requesters: req0 is instruction decode (immediate operands) and req1 is the branch/jump offset path.
- Arbitrates between the requesters with a round-robin or fixed-priority policy.
- Latches the winning request into a one-entry output buffer and drives the extender from that buffer.
- Returns the result over a valid/ready response channel with a one-cycle latency.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with req0 always winning.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_imm16  input  16  immediate for requester 0
- req0_ExtOp  input  2  extend mode for requester 0: 00 zero, 01 sign, 10 LUI, 11 default
- req0_ready  output  1  request 0 accepted this cycle
- req1_valid  input  1  requester 1 has a request
- req1_imm16  input  16  immediate for requester 1
- req1_ExtOp  input  2  extend mode for requester 1
- req1_ready  output  1  request 1 accepted this cycle
- ext_imm16  output  16  to extender imm16; equals buffered immediate
- ext_ExtOp  output  2  to extender ExtOp; equals buffered mode
- ext_out  input  32  from extender ExtOut (combinational from ext_imm16/ext_ExtOp)
- rsp_valid  output  1  response buffer holds a result
- rsp_id  output  1  requester that owns the response
- rsp_data  output  32  result; driven directly from ext_out
- rsp_ready  input  1  consumer accepts the response

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, buffered imm16=16'h0000, buffered ExtOp=2'b00, prio=RR_INIT.
  - Consequence: ext_imm16=0, ext_ExtOp=00 and rsp_data=0 after reset.
- Buffer FSM, two states:
  - EMPTY (rsp_valid=0), FULL (rsp_valid=1).
  - can_accept = EMPTY or (FULL and rsp_ready).
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL -> FULL on rsp_ready with a grant (back-to-back transfer); also FULL -> FULL when rsp_ready=0, with no state change.
- Grant rules (combinational, same cycle):
  - Grants only when can_accept and at least one reqN_valid.
  - Only one valid: that requester wins.
  - Both valid, RR_EN=1: the requester named by prio wins.
  - Both valid, RR_EN=0: req0 wins.
  - reqN_ready=1 only for the winner in a grant cycle; otherwise 0.
  - reqN_ready never depends on rsp_data.
- On grant at edge N:
  - buffer <= {winner imm16, winner ExtOp}; rsp_id <= winner; rsp_valid <= 1.
  - rsp_data is valid in cycle N+1. Latency is 1 cycle and throughput is 1 per cycle while rsp_ready=1.
- Priority update (RR_EN=1 only): on any grant, prio <= ~winner. With RR_EN=0, prio is held at RR_INIT and unused.
  - Worst-case wait with RR_EN=1 and both requesters continuously valid: one grant.
- Backpressure:
  - While FULL and rsp_ready=0, the buffer, rsp_id and rsp_data are held stable and both reqN_ready are 0.
  - Requesters must hold valid and payload until ready; the block does not check this.
- ExtOp=11 is passed through unchanged. The result is whatever the extender produces (all bits = imm16[15]).
- Reset mid-operation: a held response is dropped, rsp_valid=0 on the next cycle, and no ready is asserted during the reset cycle.
- No combinational path from rsp_ready to ext_imm16/ext_ExtOp.
- Permitted combinational paths:
  - rsp_ready -> reqN_ready, which allows back-to-back transfers.
  - ext_out -> rsp_data.

Test Plan:
- After reset, req0 imm 16'h8001 op 01, rsp_ready=1 -> req0_ready=1 in cycle 0; cycle 1: rsp_valid=1, rsp_id=0, rsp_data=32'hFFFF8001.
- RR_EN=1, RR_INIT=0, both valid for 4 cycles (req0 16'h1234 op 10, req1 16'h00F0 op 00), rsp_ready=1 -> grants alternate 0,1,0,1; responses 32'h12340000, 32'h000000F0 alternating.
- Same stimulus with RR_EN=0 -> req0 granted every cycle; req1_ready stays 0.
- Buffer FULL with 32'hFFFF8001, rsp_ready=0 for 3 cycles with req1 valid -> rsp_data, rsp_id and ext_imm16 stable; req1_ready=0; on rsp_ready=1, req1 is granted that same cycle and rsp_id=1 the next cycle.
- req1 imm 16'h7FFF op 11 -> rsp_data=32'h00000000; imm 16'h8000 op 11 -> 32'hFFFFFFFF.
- rst asserted for 1 cycle while FULL with rsp_ready=0 -> next cycle rsp_valid=0, rsp_id=0, ext_imm16=0; prio=RR_INIT, so with both valid, the first grant goes to RR_INIT.
